// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: one core request at a time over valid/ready, turned
// into an AXI4-Lite read or write; load data is aligned and extended.
// Ports: clk, rst (async active-low); core req_*/resp_* handshakes;
// AXI4-Lite AR/R and AW/W/B master channels.
module ysyx_24080014_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sign,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,

    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR,
        WR_B,
        RESP
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sign_q;

    logic              mis;
    logic [31:0]       wd_n;
    logic [3:0]        ws_n;
    logic [7:0]        rb;
    logic [15:0]       rh;
    logic [31:0]       ld;

    assign araddr = addr_q;
    assign awaddr = addr_q;

    // Alignment check on the incoming request.
    always_comb begin
        mis = 1'b0;
        unique case (req_size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = req_addr[0];
            2'b10:   mis = |req_addr[1:0];
            default: mis = 1'b1;
        endcase
    end

    // Store data is replicated to every lane; the strobe picks the lane.
    always_comb begin
        wd_n = req_wdata;
        ws_n = 4'b1111;
        unique case (req_size)
            2'b00: begin
                wd_n = {4{req_wdata[7:0]}};
                ws_n = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wd_n = {2{req_wdata[15:0]}};
                ws_n = 4'b0011 << req_addr[1:0];
            end
            default: begin
                wd_n = req_wdata;
                ws_n = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        rb = rdata[{addr_q[1:0], 3'b000} +: 8];
        rh = rdata[{addr_q[1], 4'b0000} +: 16];
        ld = rdata;
        unique case (size_q)
            2'b00:   ld = {{24{sign_q & rb[7]}}, rb};
            2'b01:   ld = {{16{sign_q & rh[15]}}, rh};
            default: ld = rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            wdata      <= '0;
            wstrb      <= '0;
            bready     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // First IDLE cycle after reset raises req_ready.
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        sign_q    <= req_sign;
                        if (mis) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_wen) begin
                            state   <= WR;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            wdata   <= wd_n;
                            wstrb   <= ws_n;
                        end else begin
                            state   <= RD_A;
                            arvalid <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= (rresp != 2'b00);
                        resp_rdata <= (rresp != 2'b00) ? '0 : ld;
                        state      <= RESP;
                    end
                end
                WR: begin
                    // A dropped valid means that channel already finished.
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) &&
                        (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid) begin
                        bready     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= (bresp != 2'b00);
                        resp_rdata <= '0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_24080014_lsu.md
Name: ysyx_24080014_lsu

Overview:
- Load/store unit sitting between the core's memory stage and the data-side AXI4-Lite bus.
- Accepts one load or store request at a time from the core over a valid/ready handshake.
- Drives the AR/R or AW/W/B channels, aligns and extends load data, and returns a result over a second valid/ready handshake.
- Replaces the core's direct combinational DPI memory access with a multi-cycle bus transaction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- req_sign  in  1  load sign-extend enable.
- resp_valid  out  1  result available.
- resp_ready  in  1  core accepts the result.
- resp_rdata  out  32  aligned, extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access, illegal size, or bus error.
- araddr  out  32
- arvalid  out  1
- arready  in  1
- rdata  in  32
- rresp  in  2
- rvalid  in  1
- rready  out  1
- awaddr  out  32
- awvalid  out  1
- awready  in  1
- wdata  out  32
- wstrb  out  4
- wvalid  out  1
- wready  in  1
- bresp  in  2
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All valid, ready and response outputs go to 0: arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err.
  - resp_rdata goes to 0.
  - req_ready goes to 1 after reset deasserts.
  - Reset mid-transaction abandons the transaction without completing it.
- States: IDLE, RD_A, RD_D, WR, WR_B, RESP.
- IDLE:
  - req_ready=1; all other handshake outputs are 0.
  - On req_valid&&req_ready, latch addr, wdata, size, sign and wen.
- Misalignment check:
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - A misaligned request goes directly to RESP with resp_err=1 and resp_rdata=0.
  - No bus channel is asserted for it.
- Load path:
  - A legal load goes to RD_A.
  - RD_A: arvalid=1, araddr=latched addr. arvalid is held until arready; arvalid must not drop before the handshake. Then go to RD_D.
  - RD_D: rready=1. On rvalid, capture the result and go to RESP.
- Load data extraction:
  - Byte lane is rdata[8*addr[1:0] +: 8]; half lane is rdata[16*addr[1] +: 16].
  - Extension follows req_sign.
  - rresp!=00 gives resp_err=1 and resp_rdata=0.
- Store path:
  - A legal store goes to WR.
  - WR: awvalid and wvalid rise in the same cycle.
  - awaddr=addr.
  - wdata is replicated across lanes: byte {4{b}}, half {2{h}}, word unchanged.
  - wstrb is 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word.
  - Each channel deasserts independently on its own handshake.
  - Go to WR_B only once both handshakes are done; either order or the same cycle is allowed.
  - WR_B: bready=1. On bvalid go to RESP; resp_err=(bresp!=00); resp_rdata=0.
- RESP:
  - resp_valid=1, with data and err held stable.
  - Go to IDLE on resp_ready. req_ready is 0 in the same cycle, so there is no back-to-back overlap.
- Latency with zero-wait slaves:
  - Load accepted in cycle 0: arvalid in cycle 1, rvalid sampled in cycle 2, resp_valid in cycle 3.
  - Stores take the same 3 cycles.
  - Misaligned access: resp_valid in cycle 1.
- req_* inputs are ignored outside IDLE.
- Bus inputs arriving in states that do not expect them are ignored.

Test Plan:
- Aligned word load, addr=0x80000004, rdata=0xDEADBEEF, slaves zero-wait -> resp_valid in cycle 3, resp_rdata=0xDEADBEEF, resp_err=0, araddr=0x80000004.
- Signed byte load at 0x80000003 with rdata=0x80FF1234 -> resp_rdata=0xFFFFFF80. The same load unsigned -> 0x00000080. Half load at 0x80000002 unsigned -> 0x000080FF.
- Half store of 0xABCD at 0x80000002:
  - Expect wdata=0xABCDABCD and wstrb=1100.
  - awready delayed 3 cycles while wready is immediate: wvalid drops after 1 cycle, awvalid is held 3 cycles.
  - resp_valid follows bvalid.
- Word load at 0x80000001 -> resp_err=1 in cycle 1, arvalid never asserted. Word load with rresp=10 -> resp_err=1, resp_rdata=0.
- resp_ready held 0 for 4 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_ready=0 throughout. The next request is accepted only after the response handshake.
- rst pulled low while in RD_D with arvalid already done -> all outputs 0 immediately. After release, req_ready=1 and a fresh load completes normally.
